// File: rtl/hdl_mux_4to1_arbiter.sv
// rtl/hdl_mux_4to1_arbiter.sv - round-robin arbiter driving the 4:1 mux selects
// Grants one of four requesters, holds while requested, rotates after MAX_HOLD cycles under contention.
module hdl_mux_4to1_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       S1,
  output logic       S0,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  // With the limit disabled the counter still must not wrap, so it parks at 255.
  localparam logic [7:0] CNT_SAT  = (MAX_HOLD == 0) ? 8'hFF : HOLD_MAX;

  state_t     state;
  logic [1:0] last;
  logic [7:0] hold_cnt;
  logic [3:0] others;
  logic [1:0] pick;
  logic       keep_ok;

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    rr_pick = from;
    // Walk from farthest to nearest so the nearest asserted bit after 'from' wins.
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    others  = req & ~gnt;
    pick    = rr_pick(others, last);
    keep_ok = (MAX_HOLD == 0) || (hold_cnt < HOLD_MAX) || (others == 4'b0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      S1       <= 1'b0;
      S0       <= 1'b0;
      valid    <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            state    <= GRANT;
            gnt      <= 4'(1) << pick;
            {S1, S0} <= pick;
            valid    <= 1'b1;
            last     <= pick;
            hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          if (req[last] && keep_ok) begin
            if (hold_cnt < CNT_SAT) hold_cnt <= hold_cnt + 8'd1;
          end else if (others != 4'b0000) begin
            gnt      <= 4'(1) << pick;
            {S1, S0} <= pick;
            valid    <= 1'b1;
            last     <= pick;
            hold_cnt <= 8'd1;
          end else begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            valid    <= 1'b0;
            hold_cnt <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdl_mux_4to1_arbiter.sv
// tb/tb_hdl_mux_4to1_arbiter.sv - directed table and sequence checks for hdl_mux_4to1_arbiter
// Instance dut uses MAX_HOLD=8, instance dut0 uses MAX_HOLD=0.
module tb_hdl_mux_4to1_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] req0 = 4'b0000;
  logic [3:0] gnt, gnt0;
  logic       s1, s0, valid, s1_0, s0_0, valid0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hdl_mux_4to1_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .S1(s1), .S0(s0), .valid(valid)
  );

  hdl_mux_4to1_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .S1(s1_0), .S0(s0_0), .valid(valid0)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] sl, input logic v,
                       input logic [3:0] eg, input logic [1:0] es, input logic ev);
    checks++;
    if (g !== eg || sl !== es || v !== ev) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b valid=%b, expected gnt=%b sel=%b valid=%b",
               name, g, sl, v, eg, es, ev);
    end
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  // Invariants on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (valid !== (|gnt) || !$onehot0(gnt) || (valid && gnt[{s1, s0}] !== 1'b1)) begin
      errors++;
      $display("FAIL invariant dut: gnt=%b sel=%b%b valid=%b", gnt, s1, s0, valid);
    end
    checks++;
    if (valid0 !== (|gnt0) || !$onehot0(gnt0) || (valid0 && gnt0[{s1_0, s0_0}] !== 1'b1)) begin
      errors++;
      $display("FAIL invariant dut0: gnt=%b sel=%b%b valid=%b", gnt0, s1_0, s0_0, valid0);
    end
  end

  initial begin
    tbl[0]  = '{4'b0001, 4'b0001, 2'b00, 1'b1};
    tbl[1]  = '{4'b0001, 4'b0001, 2'b00, 1'b1};
    tbl[2]  = '{4'b0001, 4'b0001, 2'b00, 1'b1};
    tbl[3]  = '{4'b0010, 4'b0010, 2'b01, 1'b1};
    tbl[4]  = '{4'b0110, 4'b0010, 2'b01, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0100, 2'b10, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 2'b10, 1'b0};
    tbl[7]  = '{4'b0101, 4'b0001, 2'b00, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 2'b00, 1'b0};
    tbl[9]  = '{4'b0101, 4'b0100, 2'b10, 1'b1};
    tbl[10] = '{4'b0101, 4'b0100, 2'b10, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 2'b10, 1'b0};

    #2;
    check("reset_dut", gnt, {s1, s0}, valid, 4'b0000, 2'b00, 1'b0);
    check("reset_dut0", gnt0, {s1_0, s0_0}, valid0, 4'b0000, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MAX_HOLD=0: owner 0 keeps the grant indefinitely despite req[1].
    req0 = 4'b0011;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("nolimit_hold_%0d", c), gnt0, {s1_0, s0_0}, valid0, 4'b0001, 2'b00, 1'b1);
    end
    req0 = 4'b0010;
    @(posedge clk);
    #1;
    check("nolimit_release", gnt0, {s1_0, s0_0}, valid0, 4'b0010, 2'b01, 1'b1);
    req0 = 4'b0000;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].req);
      check($sformatf("table_%0d", i), gnt, {s1, s0}, valid, tbl[i].gnt, tbl[i].sel, tbl[i].valid);
    end

    // Full contention from last=2: owners 3,0,1,2,3 for exactly 8 cycles each.
    for (int c = 0; c < 40; c++) begin
      logic [1:0] own;
      own = 2'(3 + c / 8);
      step(4'b1111);
      check($sformatf("rotate_%0d", c), gnt, {s1, s0}, valid, 4'(1) << own, own, 1'b1);
    end
    step(4'b1111);
    check("rotate_wrap", gnt, {s1, s0}, valid, 4'b0001, 2'b00, 1'b1);
    step(4'b0000);
    check("rotate_idle", gnt, {s1, s0}, valid, 4'b0000, 2'b00, 1'b0);

    // last=0 now, so requester 3 wins alone; then asynchronous reset mid-grant.
    step(4'b1000);
    check("pre_reset_grant", gnt, {s1, s0}, valid, 4'b1000, 2'b11, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", gnt, {s1, s0}, valid, 4'b0000, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", gnt, {s1, s0}, valid, 4'b0000, 2'b00, 1'b0);
    req = 4'b1001;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_priority", gnt, {s1, s0}, valid, 4'b0001, 2'b00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdl_mux_4to1_arbiter.md
Name: hdl_mux_4to1_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 mux datapath between four requesters.
- Drives the mux select lines S1/S0 and a one-hot grant vector; a requester keeps the grant while its request is held.
- An optional hold limit forces rotation so no requester can starve the others.
- Sits directly in front of hdl_mux_4to1: S1/S0 connect straight to the mux select inputs; requester i owns mux input Ii.

Parameters:
- MAX_HOLD, 8, maximum consecutive granted cycles per owner when another request is pending; 0 disables the limit. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = requester i wants mux input Ii.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- S1  output  1  mux select MSB, registered; equals the owner index bit 1.
- S0  output  1  mux select LSB, registered; equals the owner index bit 0.
- valid  output  1  high when gnt is nonzero, i.e. the mux output belongs to an owner.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-grant):
  - gnt=4'b0000, S1=0, S0=0, valid=0.
  - State=IDLE, hold_cnt=0, last pointer=3, so requester 0 has top priority after reset.
- All outputs are registered and change only on a rising clk edge after reset is released.
- States:
  - IDLE: no owner.
  - GRANT: exactly one owner.
- Priority search: from last+1 mod 4 through last+4 mod 4, the first asserted req bit wins.
- IDLE:
  - If req==0, stay IDLE.
  - Otherwise, at the next edge: go to GRANT, gnt=onehot(winner), {S1,S0}=winner, valid=1, last=winner, hold_cnt=1.
  - Latency from req to gnt is 1 cycle.
- GRANT, owner req still high:
  - If MAX_HOLD==0, or hold_cnt<MAX_HOLD, or no other req is pending: keep the grant. hold_cnt increments and saturates at MAX_HOLD.
  - Otherwise (forced rotation): the next edge grants the winner among the other requesters, searching from owner+1. hold_cnt=1 and last=new owner.
- GRANT, owner req low (release):
  - If another req is high, the next edge grants the round-robin winner directly, with no idle bubble.
  - Otherwise the next edge goes to IDLE: gnt=0, valid=0, S1/S0 hold their last value, last is unchanged.
- Simultaneous requests: resolved purely by round-robin order relative to last; there is no fixed priority apart from the reset state.
- Invariants:
  - gnt is always one-hot or zero.
  - valid equals OR of gnt.
  - When valid=1, {S1,S0} equals the index of the set gnt bit.
- hold_cnt width is 8 bits; it never wraps.

Test Plan:
- Reset then req=4'b0001 held -> one cycle later gnt=0001, S1S0=00, valid=1; the grant is held indefinitely with no other request.
- req=4'b1111 held, MAX_HOLD=8 -> owners rotate 0,1,2,3,0, each owning exactly 8 cycles; S1S0 steps 00,01,10,11,00 with no idle cycles.
- Owner 1 granted, req=4'b0110, drop req[1] -> next edge gnt=0100, S1S0=10; drop req[2] too -> next edge gnt=0000, valid=0, S1S0 stays 10.
- last=2, IDLE, req=4'b0101 -> gnt=0001 (search order 3,0,1,2 picks 0); then release and request 4'b0101 again -> gnt=0100.
- MAX_HOLD=0, req=4'b0011 with req[0] held for 50 cycles -> gnt stays 0001 for all 50 cycles; after req[0] drops, gnt=0010.
- rst_n pulsed low mid-grant (gnt=1000) -> outputs clear immediately without waiting for clk; after release with req=4'b1001 -> gnt=0001.
